// File: rtl/data_sram_responder.sv
// data_sram_responder: single-ported, byte-maskable 65-bit data SRAM with one-cycle read latency.
// Defining DSRAM_SCRUB_EN builds the post-reset scrub sequencer that zeroes every word before use.
module data_sram_responder #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [8:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [64:0] data_sram_wdata,
    output logic [64:0] data_sram_rdata,
    output logic        init_busy,
    output logic        err_oob
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    // Replace only the lanes selected by wen; bit 64 is its own lane.
    function automatic logic [64:0] merge_lanes(input logic [64:0] old_word,
                                                input logic [64:0] new_word,
                                                input logic [8:0]  wen);
        logic [64:0] res;
        res = old_word;
        for (int i = 0; i < 8; i++) begin
            if (wen[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        if (wen[8]) begin
            res[64] = new_word[64];
        end else begin
            res[64] = old_word[64];
        end
        return res;
    endfunction

    logic [64:0] mem_q [DEPTH];

    logic [64:0] rdata_q, rdata_d;
    logic        err_oob_q, err_oob_d;
    logic        in_range_s;
    logic        req_write_s;
    logic        scrubbing_s;
    idx_t        scrub_idx_s;
    idx_t        req_idx_s;
    idx_t        mem_idx_s;
    logic        mem_we_s;
    logic [64:0] mem_wdata_s;
    logic [64:0] old_word_s;
    logic [64:0] merged_s;
    logic [2:0]  addr_unused_s;

    assign addr_unused_s = data_sram_addr[2:0];
    assign req_idx_s     = data_sram_addr[DEPTH_LOG2+2:3];
    assign in_range_s    = (data_sram_addr[31:DEPTH_LOG2+3] == BASE_ADDR[31:DEPTH_LOG2+3]);
    assign req_write_s   = (data_sram_wen != 9'h000);
    assign old_word_s    = mem_q[req_idx_s];
    assign merged_s      = merge_lanes(old_word_s, data_sram_wdata, data_sram_wen);

`ifdef DSRAM_SCRUB_EN
    typedef enum logic [0:0] {
        ST_SCRUB = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam idx_t CNT_LAST = {DEPTH_LOG2{1'b1}};
    localparam idx_t CNT_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    state_t state_q, state_d;
    idx_t   counter_q, counter_d;
    logic   init_busy_q, init_busy_d;

    // Scrub sequencer next-state: walk every index once, then park in READY.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        init_busy_d = init_busy_q;
        case (state_q)
            ST_SCRUB: begin
                counter_d = counter_q + CNT_ONE;
                if (counter_q == CNT_LAST) begin
                    state_d     = ST_READY;
                    init_busy_d = 1'b0;
                end else begin
                    state_d     = ST_SCRUB;
                    init_busy_d = 1'b1;
                end
            end
            ST_READY: begin
                state_d     = ST_READY;
                counter_d   = counter_q;
                init_busy_d = 1'b0;
            end
            default: begin
                state_d     = ST_SCRUB;
                counter_d   = {DEPTH_LOG2{1'b0}};
                init_busy_d = 1'b1;
            end
        endcase
    end

    // Scrub sequencer state and busy flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SCRUB;
            counter_q   <= {DEPTH_LOG2{1'b0}};
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            init_busy_q <= init_busy_d;
        end
    end

    assign scrubbing_s = (state_q == ST_SCRUB);
    assign scrub_idx_s = counter_q;
    assign init_busy   = init_busy_q;
`else
    assign scrubbing_s = 1'b0;
    assign scrub_idx_s = {DEPTH_LOG2{1'b0}};
    assign init_busy   = 1'b0;
`endif

    // Request decode: scrub owns the array port; otherwise serve read, write-first write, or flag OOB.
    always_comb begin
        rdata_d     = rdata_q;
        err_oob_d   = err_oob_q;
        mem_we_s    = 1'b0;
        mem_idx_s   = req_idx_s;
        mem_wdata_s = merged_s;
        if (scrubbing_s) begin
            mem_we_s    = 1'b1;
            mem_idx_s   = scrub_idx_s;
            mem_wdata_s = 65'h0;
            if (data_sram_en) begin
                err_oob_d = 1'b1;
            end else begin
                err_oob_d = err_oob_q;
            end
        end else if (data_sram_en) begin
            if (!in_range_s) begin
                rdata_d   = 65'h0;
                err_oob_d = 1'b1;
            end else if (req_write_s) begin
                mem_we_s = 1'b1;
                rdata_d  = merged_s;
            end else begin
                rdata_d = old_word_s;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Registered read data and sticky error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q   <= 65'h0;
            err_oob_q <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            err_oob_q <= err_oob_d;
        end
    end

    // Storage array; contents survive reset and are cleared only by the scrub.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[mem_idx_s] <= mem_wdata_s;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign err_oob         = err_oob_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder (DEPTH_LOG2=4); adapts to whether DSRAM_SCRUB_EN is defined.
`timescale 1ns/1ps
module tb_data_sram_responder;

    logic        clock;
    logic        reset;
    logic        en;
    logic [8:0]  wen;
    logic [31:0] addr;
    logic [64:0] wdata;
    logic [64:0] rdata;
    logic        init_busy;
    logic        err_oob;

    int tests_run;
    int tests_failed;

    typedef struct packed {
        logic [64:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        en;
        logic [8:0]  wen;
        logic [31:0] addr;
        logic [64:0] wdata;
        logic [64:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[18];

    localparam logic [64:0] V0 = 65'h1_0F0F_0000_AAAA_5555;
`ifdef DSRAM_SCRUB_EN
    localparam logic BUSY_AT_RESET = 1'b1;
`else
    localparam logic BUSY_AT_RESET = 1'b0;
`endif

    data_sram_responder #(
        .DEPTH_LOG2(4),
        .BASE_ADDR (32'h8000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .data_sram_en   (en),
        .data_sram_wen  (wen),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata),
        .init_busy      (init_busy),
        .err_oob        (err_oob)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request at the falling edge; expectation is queued and popped after the next rising edge.
    task automatic do_req(input string name, input logic e, input logic [8:0] w,
                          input logic [31:0] a, input logic [64:0] d,
                          input logic [64:0] er, input logic ee);
        exp_t x;
        @(negedge clock);
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
        sb_q.push_back('{rdata: er, err: ee});
        @(posedge clock);
        #1;
        x = sb_q.pop_front();
        check({name, " rdata"}, rdata, x.rdata);
        check({name, " err_oob"}, {64'h0, err_oob}, {64'h0, x.err});
        check({name, " init_busy"}, {64'h0, init_busy}, 65'h0);
    endtask

    task automatic count_scrub(input string name);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clock);
            #1;
            n++;
            if (!init_busy) done = 1'b1;
        end
        check(name, 65'(n), 65'd16);
    endtask

    task automatic idle();
        @(negedge clock);
        en  = 1'b0;
        wen = 9'h000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] w0_exp;
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0;
        en    = 1'b0;
        wen   = 9'h000;
        addr  = 32'h0;
        wdata = 65'h0;
        #1;
        check("reset rdata", rdata, 65'h0);
        check("reset err_oob", {64'h0, err_oob}, 65'h0);
        check("reset init_busy", {64'h0, init_busy}, {64'h0, BUSY_AT_RESET});
        repeat (3) @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;

`ifdef DSRAM_SCRUB_EN
        count_scrub("scrub length");
        check("scrub err_oob", {64'h0, err_oob}, 65'h0);
        for (int i = 0; i < 16; i++) begin
            do_req("scrub readback", 1'b1, 9'h000, 32'h8000_0000 + 32'(i * 8), 65'h0, 65'h0, 1'b0);
        end
        w0_exp = 65'h0;
`else
        do_req("first write", 1'b1, 9'h1FF, 32'h8000_0000, V0, V0, 1'b0);
        do_req("first read", 1'b1, 9'h000, 32'h8000_0000, 65'h0, V0, 1'b0);
        w0_exp = V0;
`endif

        vecs[0]  = '{1'b1, 9'h1FF, 32'h8000_0008, 65'h1_FFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[1]  = '{1'b1, 9'h001, 32'h8000_0008, 65'h0_0000_0000_0000_00AB, 65'h1_FFFF_FFFF_FFFF_FFAB, 1'b0};
        vecs[2]  = '{1'b1, 9'h000, 32'h8000_0008, 65'h0,                     65'h1_FFFF_FFFF_FFFF_FFAB, 1'b0};
        vecs[3]  = '{1'b1, 9'h1FF, 32'h8000_0010, 65'h0_1234_5678_9ABC_DEF0, 65'h0_1234_5678_9ABC_DEF0, 1'b0};
        vecs[4]  = '{1'b1, 9'h000, 32'h8000_0010, 65'h0,                     65'h0_1234_5678_9ABC_DEF0, 1'b0};
        vecs[5]  = '{1'b0, 9'h000, 32'h8000_0008, 65'h0,                     65'h0_1234_5678_9ABC_DEF0, 1'b0};
        vecs[6]  = '{1'b1, 9'h100, 32'h8000_0010, 65'h1_5555_5555_5555_5555, 65'h1_1234_5678_9ABC_DEF0, 1'b0};
        vecs[7]  = '{1'b1, 9'h0F0, 32'h8000_0010, 65'h0_AABB_CCDD_1111_2222, 65'h1_AABB_CCDD_9ABC_DEF0, 1'b0};
        vecs[8]  = '{1'b1, 9'h000, 32'h8000_0017, 65'h0,                     65'h1_AABB_CCDD_9ABC_DEF0, 1'b0};
        vecs[9]  = '{1'b1, 9'h1FF, 32'h8000_0078, 65'h0_0000_0000_0000_0001, 65'h0_0000_0000_0000_0001, 1'b0};
        vecs[10] = '{1'b1, 9'h000, 32'h8000_0078, 65'h0,                     65'h0_0000_0000_0000_0001, 1'b0};
        vecs[11] = '{1'b1, 9'h1FF, 32'h9000_0000, 65'h1_FFFF_FFFF_FFFF_FFFF, 65'h0,                     1'b1};
        vecs[12] = '{1'b1, 9'h000, 32'h8000_0000, 65'h0,                     w0_exp,                    1'b1};
        vecs[13] = '{1'b1, 9'h000, 32'h8000_0080, 65'h0,                     65'h0,                     1'b1};
        vecs[14] = '{1'b1, 9'h000, 32'h8000_0008, 65'h0,                     65'h1_FFFF_FFFF_FFFF_FFAB, 1'b1};
        vecs[15] = '{1'b1, 9'h000, 32'h7FFF_FFF8, 65'h0,                     65'h0,                     1'b1};
        vecs[16] = '{1'b0, 9'h000, 32'h8000_0010, 65'h0,                     65'h0,                     1'b1};
        vecs[17] = '{1'b1, 9'h000, 32'h8000_0078, 65'h0,                     65'h0_0000_0000_0000_0001, 1'b1};

        for (int i = 0; i < 18; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].en, vecs[i].wen, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
        end
        idle();

        // Asynchronous reset mid-operation clears outputs without a clock edge.
        #2 reset = 1'b0;
        #1;
        check("midop reset rdata", rdata, 65'h0);
        check("midop reset err_oob", {64'h0, err_oob}, 65'h0);
        check("midop reset init_busy", {64'h0, init_busy}, {64'h0, BUSY_AT_RESET});
        @(posedge clock);
        #2 reset = 1'b1;

`ifdef DSRAM_SCRUB_EN
        repeat (2) @(posedge clock);
        @(negedge clock);
        en   = 1'b1;
        wen  = 9'h000;
        addr = 32'h8000_0008;
        @(posedge clock);
        #1;
        check("early req err_oob", {64'h0, err_oob}, 65'h1);
        check("early req rdata", rdata, 65'h0);
        check("early req init_busy", {64'h0, init_busy}, 65'h1);
        @(negedge clock);
        en = 1'b0;
        repeat (5) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midscrub reset init_busy", {64'h0, init_busy}, 65'h1);
        check("midscrub reset err_oob", {64'h0, err_oob}, 65'h0);
        check("midscrub reset rdata", rdata, 65'h0);
        @(posedge clock);
        #2 reset = 1'b1;
        count_scrub("rescrub length");
        check("rescrub err_oob", {64'h0, err_oob}, 65'h0);
        do_req("rescrub word1", 1'b1, 9'h000, 32'h8000_0008, 65'h0, 65'h0, 1'b0);
        do_req("rescrub word15", 1'b1, 9'h000, 32'h8000_0078, 65'h0, 65'h0, 1'b0);
`else
        do_req("post reset write", 1'b1, 9'h1FF, 32'h8000_0020, 65'h0_CAFE_F00D_0BAD_BEEF,
               65'h0_CAFE_F00D_0BAD_BEEF, 1'b0);
        do_req("post reset read", 1'b1, 9'h000, 32'h8000_0020, 65'h0, 65'h0_CAFE_F00D_0BAD_BEEF, 1'b0);
`endif
        idle();
        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
